i2c_target: RTL and testbench

- I2C target (slave) that sits at the far end of the bus driven by the team's I2C generator.
- Samples the generator's SCL and SDA and detects START/STOP.
- Matches a 7-bit address, then either receives up to two write bytes or returns a 16-bit read word, driving ACK/data back on SDA_IN.
- Closes the loop for generator verification and serves as reusable register-port front end.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_bus_sync.sv | 32 +++
 rtl/i2c_target.sv | 198 +++++++++++++++++++
 tb/tb_i2c_target.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

  localparam int ADDR_W = 7;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_RD_BYTE,
    S_RD_ACK,
    S_WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Registers SCL/SDA and flags clock edges plus START/STOP conditions.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_q;
  logic sda_q;

  // Reset to the idle-bus level so no edge is seen on release of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  assign scl_rise  = !scl_q & scl;
  assign scl_fall  = scl_q & !scl;
  assign start_det = scl_q & scl & sda_q & !sda;
  assign stop_det  = scl_q & scl & !sda_q & sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, up to BYTES write bytes, BYTES-byte read word.
//   state       | meaning
//   IDLE        | bus free, waiting for START
//   ADDR        | shifting in address + R/W bit
//   ADDR_ACK    | pulling SDA low for the address ACK
//   WR_BYTE     | shifting in a write byte
//   WR_ACK      | ACK (or NACK on overrun) of a write byte
//   RD_BYTE     | presenting read bits, MSB first
//   RD_ACK      | SDA released, sampling controller ACK/NACK
//   WAIT_STOP   | SDA released until START or STOP
module i2c_target
  import i2c_pkg::*;
#(
  parameter int BYTES = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 SCL,
  input  logic                 SDA_OUT,
  input  logic                 SDA_OE,
  input  logic [ADDR_W-1:0]    I2C_ADDR,
  input  logic [8*BYTES-1:0]   RD_DATA,
  output logic                 SDA_IN,
  output logic [8*BYTES-1:0]   WR_DATA,
  output logic [1:0]           WR_LEN,
  output logic                 WR_VALID,
  output logic                 BUSY
);

  localparam int         W       = 8 * BYTES;
  localparam logic [1:0] BYTES_L = 2'(BYTES);

  logic sda;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t         state, state_nx;
  logic [3:0]     bit_cnt, bit_nx;
  logic [7:0]     shreg, shreg_nx;
  logic           rnw, rnw_nx;
  logic [1:0]     byte_cnt, byte_nx;
  logic [W-1:0]   rd_word, rd_nx;
  logic           sda_nx;
  logic [W-1:0]   wr_data_nx;
  logic [1:0]     wr_len_nx;
  logic           wr_valid_nx;

  assign sda  = SDA_OE ? SDA_OUT : 1'b1;
  assign BUSY = (state != S_IDLE);

  i2c_bus_sync u_sync (
    .clk       (CLK),
    .rst_n     (RESET),
    .scl       (SCL),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      rnw      <= 1'b0;
      byte_cnt <= '0;
      rd_word  <= '0;
      SDA_IN   <= 1'b1;
      WR_DATA  <= '0;
      WR_LEN   <= '0;
      WR_VALID <= 1'b0;
    end else begin
      state    <= state_nx;
      bit_cnt  <= bit_nx;
      shreg    <= shreg_nx;
      rnw      <= rnw_nx;
      byte_cnt <= byte_nx;
      rd_word  <= rd_nx;
      SDA_IN   <= sda_nx;
      WR_DATA  <= wr_data_nx;
      WR_LEN   <= wr_len_nx;
      WR_VALID <= wr_valid_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    bit_nx      = bit_cnt;
    shreg_nx    = shreg;
    rnw_nx      = rnw;
    byte_nx     = byte_cnt;
    rd_nx       = rd_word;
    sda_nx      = SDA_IN;
    wr_data_nx  = WR_DATA;
    wr_len_nx   = WR_LEN;
    wr_valid_nx = 1'b0;

    if (stop_det || start_det) begin
      // Either bus condition closes an open write and releases SDA at once.
      if (byte_cnt != 2'd0) begin
        wr_valid_nx = 1'b1;
        wr_len_nx   = byte_cnt;
      end
      byte_nx  = '0;
      bit_nx   = '0;
      sda_nx   = 1'b1;
      state_nx = stop_det ? S_IDLE : S_ADDR;
    end else begin
      case (state)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise) begin
            shreg_nx = {shreg[6:0], sda};
            bit_nx   = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (shreg[6:0] == I2C_ADDR) begin
                rnw_nx   = sda;
                state_nx = S_ADDR_ACK;
              end else begin
                state_nx = S_WAIT_STOP;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          // First fall starts the ACK, second fall (after the ACK clock) ends it.
          if (scl_fall) begin
            bit_nx = '0;
            if (bit_cnt == 4'd8) begin
              sda_nx = ACK;
            end else if (rnw) begin
              rd_nx    = RD_DATA;
              sda_nx   = RD_DATA[W-1];
              state_nx = S_RD_BYTE;
            end else begin
              sda_nx   = NACK;
              state_nx = S_WR_BYTE;
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_rise) begin
            shreg_nx = {shreg[6:0], sda};
            bit_nx   = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state_nx = S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              bit_nx = '0;
              if (byte_cnt < BYTES_L) begin
                sda_nx     = ACK;
                wr_data_nx = {WR_DATA[W-9:0], shreg};
                byte_nx    = byte_cnt + 2'd1;
              end else begin
                state_nx = S_WAIT_STOP;
              end
            end else begin
              sda_nx   = NACK;
              state_nx = S_WR_BYTE;
            end
          end
        end
        S_RD_BYTE: begin
          if (scl_rise) bit_nx = bit_cnt + 4'd1;
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_nx   = 1'b1;
              state_nx = S_RD_ACK;
            end else begin
              // Fill with ones so reads past the word return 0xFF.
              rd_nx  = {rd_word[W-2:0], 1'b1};
              sda_nx = rd_word[W-2];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise && sda == NACK) begin
            state_nx = S_WAIT_STOP;
          end else if (scl_fall) begin
            bit_nx   = '0;
            rd_nx    = {rd_word[W-2:0], 1'b1};
            sda_nx   = rd_word[W-2];
            state_nx = S_RD_BYTE;
          end
        end
        S_WAIT_STOP: sda_nx = 1'b1;
        default: begin
          state_nx = S_IDLE;
          sda_nx   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench: bit-banged I2C controller driving i2c_target.
module tb_i2c_target;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl;
  logic        sda_out;
  logic        sda_oe;
  logic [6:0]  i2c_addr;
  logic [15:0] rd_data;
  logic        sda_in;
  logic [15:0] wr_data;
  logic [1:0]  wr_len;
  logic        wr_valid;
  logic        busy;

  always #5 clk = ~clk;

  i2c_target #(.BYTES(2)) dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .SCL      (scl),
    .SDA_OUT  (sda_out),
    .SDA_OE   (sda_oe),
    .I2C_ADDR (i2c_addr),
    .RD_DATA  (rd_data),
    .SDA_IN   (sda_in),
    .WR_DATA  (wr_data),
    .WR_LEN   (wr_len),
    .WR_VALID (wr_valid),
    .BUSY     (busy)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          pulses   = 0;
  int          low_cnt  = 0;
  int          hold_viol = 0;
  logic [15:0] last_data = '0;
  logic [1:0]  last_len  = '0;
  logic        scl_prev  = 1'b1;
  logic        sda_prev  = 1'b1;

  // Stimulus changes at posedge+1, so the negedge monitor never races it.
  always @(negedge clk) begin
    if (wr_valid) begin
      pulses++;
      last_data = wr_data;
      last_len  = wr_len;
    end
    if (sda_in == 1'b0) low_cnt++;
    if (rst_n && scl && scl_prev && sda_in !== sda_prev) hold_viol++;
    scl_prev = scl;
    sda_prev = sda_in;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_bit(input logic drive, input logic b, output logic smp);
    sda_oe  = drive;
    sda_out = b;
    tick(2);
    scl = 1'b1;
    tick(2);
    smp = sda_in;
    tick(2);
    scl = 1'b0;
    tick(2);
  endtask

  task automatic gen_start();
    sda_oe  = 1'b1;
    sda_out = 1'b1;
    tick(2);
    scl = 1'b1;
    tick(2);
    sda_out = 1'b0;
    tick(3);
    scl = 1'b0;
    tick(2);
  endtask

  task automatic gen_stop();
    sda_oe  = 1'b1;
    sda_out = 1'b0;
    tick(2);
    scl = 1'b1;
    tick(2);
    sda_out = 1'b1;
    tick(3);
    sda_oe = 1'b0;
    tick(1);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(1'b1, d[i], s);
    bus_bit(1'b0, 1'b1, ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b0, 1'b1, s);
      d[i] = s;
    end
    bus_bit(1'b1, ack, s);
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] bytes;
    int          nb;
    logic [3:0]  exp_ack;
    logic        exp_low;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [1:0]  exp_len;
  } wr_vec_t;

  wr_vec_t     vec [5];
  logic        a;
  logic [3:0]  acks;
  logic [7:0]  d;
  logic [7:0]  addr_byte;
  int          p0;
  int          l0;

  initial begin
    vec[0] = '{7'h1A, 32'h34AAAE00, 3, 4'b0000, 1'b1, 1'b1, 16'hAAAE, 2'd2};
    vec[1] = '{7'h1A, 32'h36550000, 2, 4'b0011, 1'b0, 1'b0, 16'h0000, 2'd0};
    vec[2] = '{7'h1A, 32'h34112233, 4, 4'b1000, 1'b1, 1'b1, 16'h1122, 2'd2};
    vec[3] = '{7'h1A, 32'h345C0000, 2, 4'b0000, 1'b1, 1'b1, 16'h225C, 2'd1};
    vec[4] = '{7'h50, 32'hA0010200, 3, 4'b0000, 1'b1, 1'b1, 16'h0102, 2'd2};

    rst_n    = 1'b0;
    scl      = 1'b1;
    sda_out  = 1'b1;
    sda_oe   = 1'b0;
    i2c_addr = 7'h1A;
    rd_data  = 16'h5AC3;
    tick(3);
    check("rst_sda_in",   32'(sda_in),   32'h1);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_wr_valid", 32'(wr_valid), 32'h0);
    check("rst_wr_len",   32'(wr_len),   32'h0);
    check("rst_wr_data",  32'(wr_data),  32'h0);
    rst_n = 1'b1;
    tick(3);

    for (int v = 0; v < 5; v++) begin
      i2c_addr = vec[v].addr;
      p0   = pulses;
      l0   = low_cnt;
      acks = '0;
      gen_start();
      check($sformatf("v%0d_busy_start", v), 32'(busy), 32'h1);
      for (int b = 0; b < vec[v].nb; b++) begin
        send_byte(vec[v].bytes[31-8*b -: 8], a);
        acks[b] = a;
      end
      gen_stop();
      tick(2);
      check($sformatf("v%0d_acks", v), 32'(acks), 32'(vec[v].exp_ack));
      check($sformatf("v%0d_pulses", v), 32'(pulses - p0), 32'(vec[v].exp_valid));
      check($sformatf("v%0d_sda_low_seen", v), 32'(low_cnt != l0), 32'(vec[v].exp_low));
      check($sformatf("v%0d_busy_stop", v), 32'(busy), 32'h0);
      if (vec[v].exp_valid) begin
        check($sformatf("v%0d_wr_data", v), 32'(last_data), 32'(vec[v].exp_data));
        check($sformatf("v%0d_wr_len", v), 32'(last_len), 32'(vec[v].exp_len));
      end
    end

    // Read: 0x5A ACKed, 0xC3 NACKed.
    i2c_addr = 7'h1A;
    rd_data  = 16'h5AC3;
    p0 = pulses;
    gen_start();
    send_byte(8'h35, a);
    check("rd_addr_ack", 32'(a), 32'h0);
    recv_byte(d, 1'b0);
    check("rd_byte0", 32'(d), 32'h5A);
    recv_byte(d, 1'b1);
    check("rd_byte1", 32'(d), 32'hC3);
    tick(1);
    check("rd_release_after_nack", 32'(sda_in), 32'h1);
    check("rd_busy_before_stop", 32'(busy), 32'h1);
    gen_stop();
    tick(1);
    check("rd_busy_after_stop", 32'(busy), 32'h0);
    check("rd_no_wr_pulse", 32'(pulses - p0), 32'h0);

    // Repeated START closes a 1-byte write, then read past the word end.
    rd_data = 16'hE10F;
    p0 = pulses;
    gen_start();
    send_byte(8'h34, a);
    check("rs_addr_ack", 32'(a), 32'h0);
    send_byte(8'h77, a);
    check("rs_data_ack", 32'(a), 32'h0);
    gen_start();
    check("rs_pulse", 32'(pulses - p0), 32'h1);
    check("rs_len", 32'(last_len), 32'h1);
    check("rs_data_lo", 32'(last_data[7:0]), 32'h77);
    check("rs_busy", 32'(busy), 32'h1);
    send_byte(8'h35, a);
    check("rs_rd_addr_ack", 32'(a), 32'h0);
    recv_byte(d, 1'b0);
    check("rs_rd_byte0", 32'(d), 32'hE1);
    recv_byte(d, 1'b0);
    check("rs_rd_byte1", 32'(d), 32'h0F);
    recv_byte(d, 1'b1);
    check("rs_rd_past_end", 32'(d), 32'hFF);
    gen_stop();
    tick(1);
    check("rs_no_pulse_at_stop", 32'(pulses - p0), 32'h1);

    // Reset while the address ACK is being driven.
    addr_byte = 8'h34;
    gen_start();
    for (int i = 7; i >= 0; i--) bus_bit(1'b1, addr_byte[i], a);
    sda_oe = 1'b0;
    tick(1);
    check("rst_mid_ack_driven", 32'(sda_in), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_sda_release", 32'(sda_in), 32'h1);
    check("rst_mid_busy", 32'(busy), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    p0 = pulses;
    gen_start();
    send_byte(8'h34, a);
    check("post_rst_addr_ack", 32'(a), 32'h0);
    send_byte(8'h99, a);
    check("post_rst_data_ack", 32'(a), 32'h0);
    gen_stop();
    tick(2);
    check("post_rst_pulse", 32'(pulses - p0), 32'h1);
    check("post_rst_data", 32'(last_data), 32'h0099);
    check("post_rst_len", 32'(last_len), 32'h1);

    check("sda_stable_while_scl_high", 32'(hold_viol), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
